// File: rtl/sc2110_word_align_ctrl.sv
// SC2110 LVDS word-alignment training controller: compares deserialized words against a
// training word and drives byte-slip pulses until lock. Optional watchdog: `define ALIGN_TIMEOUT_EN.
`timescale 1ns/1ps
module sc2110_word_align_ctrl #(
  parameter logic [47:0] TRAIN_WORD   = 48'h000FFF000FFF,
  parameter int          MATCH_NUM    = 16,
  parameter int          SETTLE_WORDS = 4,
  parameter int          MAX_TRIES    = 12,
  parameter int          TIMEOUT_CYC  = 1024
) (
  input  logic        i_lvds_clk,
  input  logic        i_rstn,
  input  logic        i_train_start,
  input  logic        i_data_valid,
  input  logic [47:0] i_data,
  output logic [3:0]  o_bitslip,
  output logic        o_aligned,
  output logic        o_align_fail,
  output logic        o_busy,
  output logic [2:0]  o_slip_pos,
  output logic [7:0]  o_try_cnt
);

  // Handshake: one word is consumed on every i_lvds_clk edge with i_data_valid high;
  // there is no backpressure, and words arriving in SLIP, IDLE, LOCKED or FAIL are dropped.
  typedef enum logic [2:0] {IDLE, CHECK, SLIP, SETTLE, LOCKED, FAIL} state_t;

  localparam logic [7:0] MATCH_LAST  = 8'(MATCH_NUM - 1);
  localparam logic [3:0] SETTLE_LAST = 4'(SETTLE_WORDS - 1);
  localparam logic [7:0] TRIES_MAX   = 8'(MAX_TRIES);

  state_t     state;
  logic [7:0] match_cnt;
  logic [3:0] settle_cnt;
  logic       word_match;
  logic [2:0] next_pos;
  logic       wd_expire;

  assign word_match = (i_data == TRAIN_WORD);
  assign next_pos   = (o_slip_pos == 3'd5) ? 3'd0 : o_slip_pos + 3'd1;

`ifdef ALIGN_TIMEOUT_EN
  localparam int              WD_W    = $clog2(TIMEOUT_CYC + 1);
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYC - 1);

  logic [WD_W-1:0] wd_cnt;
  logic            wd_active;

  assign wd_active = (state == CHECK) || (state == SETTLE);
  assign wd_expire = wd_active && !i_data_valid && (wd_cnt == WD_LAST);

  // Every entry into CHECK or SETTLE passes through a restart, a valid word or SLIP, all of which clear it.
  always_ff @(posedge i_lvds_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      wd_cnt <= '0;
    end else if (i_train_start || i_data_valid || !wd_active) begin
      wd_cnt <= '0;
    end else if (!wd_expire) begin
      wd_cnt <= wd_cnt + 1'b1;
    end
  end
`else
  assign wd_expire = 1'b0;
`endif

  always_ff @(posedge i_lvds_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      state        <= IDLE;
      match_cnt    <= 8'd0;
      settle_cnt   <= 4'd0;
      o_bitslip    <= 4'h0;
      o_aligned    <= 1'b0;
      o_align_fail <= 1'b0;
      o_busy       <= 1'b0;
      o_slip_pos   <= 3'd0;
      o_try_cnt    <= 8'd0;
    end else begin
      o_bitslip <= 4'h0;
      if (i_train_start) begin
        state        <= CHECK;
        match_cnt    <= 8'd0;
        settle_cnt   <= 4'd0;
        o_try_cnt    <= 8'd0;
        o_aligned    <= 1'b0;
        o_align_fail <= 1'b0;
        o_busy       <= 1'b1;
        // A pulse already on the wire still moves the deserializer.
        if (state == SLIP) o_slip_pos <= next_pos;
      end else begin
        case (state)
          CHECK: begin
            if (wd_expire) begin
              state        <= FAIL;
              o_align_fail <= 1'b1;
              o_busy       <= 1'b0;
            end else if (i_data_valid) begin
              if (word_match) begin
                match_cnt <= match_cnt + 8'd1;
                if (match_cnt == MATCH_LAST) begin
                  state     <= LOCKED;
                  o_aligned <= 1'b1;
                  o_busy    <= 1'b0;
                end
              end else begin
                match_cnt <= 8'd0;
                if (o_try_cnt == TRIES_MAX) begin
                  state        <= FAIL;
                  o_align_fail <= 1'b1;
                  o_busy       <= 1'b0;
                end else begin
                  state     <= SLIP;
                  o_bitslip <= 4'hF;
                end
              end
            end
          end
          SLIP: begin
            state      <= SETTLE;
            settle_cnt <= 4'd0;
            o_slip_pos <= next_pos;
            if (o_try_cnt != 8'hFF) o_try_cnt <= o_try_cnt + 8'd1;
          end
          SETTLE: begin
            if (wd_expire) begin
              state        <= FAIL;
              o_align_fail <= 1'b1;
              o_busy       <= 1'b0;
            end else if (i_data_valid) begin
              if (settle_cnt == SETTLE_LAST) begin
                state      <= CHECK;
                settle_cnt <= 4'd0;
              end else begin
                settle_cnt <= settle_cnt + 4'd1;
              end
            end
          end
          IDLE, LOCKED, FAIL: begin
            state <= state;
          end
          default: begin
            state  <= IDLE;
            o_busy <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_sc2110_word_align_ctrl.sv
// Directed bench for sc2110_word_align_ctrl; slip pulses are checked against a queue of expected
// {slip_pos, try_cnt} records. Build with ALIGN_TIMEOUT_EN to exercise the watchdog at TIMEOUT_CYC=64.
`timescale 1ns/1ps
module tb_sc2110_word_align_ctrl;

  localparam logic [47:0] TRAIN = 48'h000FFF000FFF;

  logic        i_lvds_clk;
  logic        i_rstn;
  logic        i_train_start;
  logic        i_data_valid;
  logic [47:0] i_data;
  logic [3:0]  o_bitslip;
  logic        o_aligned;
  logic        o_align_fail;
  logic        o_busy;
  logic [2:0]  o_slip_pos;
  logic [7:0]  o_try_cnt;

  logic [10:0] exp_q[$];
  int          total = 0;
  int          bad = 0;
  int          tb_pos = 0;
  int          gap = 99;
  int          pulse_cnt = 0;
  int          base;
  logic        prev_pulse = 1'b0;
  logic        pend = 1'b0;

  sc2110_word_align_ctrl #(.TIMEOUT_CYC(64)) dut (
    .i_lvds_clk    (i_lvds_clk),
    .i_rstn        (i_rstn),
    .i_train_start (i_train_start),
    .i_data_valid  (i_data_valid),
    .i_data        (i_data),
    .o_bitslip     (o_bitslip),
    .o_aligned     (o_aligned),
    .o_align_fail  (o_align_fail),
    .o_busy        (o_busy),
    .o_slip_pos    (o_slip_pos),
    .o_try_cnt     (o_try_cnt)
  );

  // clock / reset
  initial i_lvds_clk = 1'b0;
  always #5 i_lvds_clk = ~i_lvds_clk;

  function automatic logic [13:0] stat();
    return {o_aligned, o_align_fail, o_busy, o_slip_pos, o_try_cnt};
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // A simple deserializer stand-in: only position 3 yields the training word.
  function automatic logic [47:0] word_for(input int pos);
    logic [31:0] r;
    r = $urandom;
    return (pos == 3) ? TRAIN : {16'hDEAD, r};
  endfunction

  // Mid-cycle monitor step: bitslip legality, pulse spacing and the scoreboard pop.
  task automatic mon_step();
    logic [10:0] e;
    if (!i_rstn) begin
      tb_pos = 0; gap = 99; prev_pulse = 1'b0; pend = 1'b0;
      return;
    end
    if (pend) begin
      pend = 1'b0;
      e = exp_q.pop_front();
      check("pulse_record", {o_slip_pos, o_try_cnt}, e);
    end
    check("bitslip_code", (o_bitslip == 4'h0) || (o_bitslip == 4'hF), 1);
    if (o_bitslip == 4'hF) begin
      check("pulse_back_to_back", prev_pulse, 0);
      check("pulse_gap_ge5", gap >= 5, 1);
      check("pulse_expected", exp_q.size() != 0, 1);
      if (exp_q.size() != 0) pend = 1'b1;
      pulse_cnt++;
      tb_pos = (tb_pos + 1) % 6;
      gap = 0;
    end else if (i_data_valid) begin
      gap++;
    end
    if (i_train_start) gap = 99;
    prev_pulse = (o_bitslip == 4'hF);
  endtask

  // driver: one clock of stimulus, monitored at the falling edge, sampled 1ns after the rising edge
  task automatic drive(input logic v, input logic [47:0] d, input logic s);
    i_data_valid  = v;
    i_data        = d;
    i_train_start = s;
    @(negedge i_lvds_clk);
    mon_step();
    @(posedge i_lvds_clk);
    #1;
    i_data_valid  = 1'b0;
    i_train_start = 1'b0;
  endtask

  initial begin
    i_rstn = 1'b0; i_train_start = 1'b0; i_data_valid = 1'b0; i_data = '0;
    repeat (3) @(posedge i_lvds_clk);
    #1;
    check("reset_state", {stat(), o_bitslip}, 18'h0);
    i_rstn = 1'b1;
    drive(1, TRAIN, 0);
    check("idle_ignores_data", stat(), 14'h0);

    // aligned from start
    base = pulse_cnt;
    drive(0, '0, 1);
    check("s1_start", stat(), {3'b001, 3'd0, 8'd0});
    for (int i = 0; i < 15; i++) drive(1, TRAIN, 0);
    check("s1_before_16th", stat(), {3'b001, 3'd0, 8'd0});
    drive(1, TRAIN, 0);
    check("s1_locked", stat(), {3'b100, 3'd0, 8'd0});
    check("s1_no_pulses", pulse_cnt - base, 0);

    // misaligned by 3 positions
    base = pulse_cnt;
    drive(0, '0, 1);
    check("s2_restart", stat(), {3'b001, 3'd0, 8'd0});
    for (int i = 1; i <= 3; i++) exp_q.push_back({3'(i), 8'(i)});
    for (int i = 0; i < 200 && !o_aligned; i++) drive(1, word_for(tb_pos), 0);
    check("s2_locked", stat(), {3'b100, 3'd3, 8'd3});
    check("s2_pulses", pulse_cnt - base, 3);
    check("s2_queue_empty", exp_q.size(), 0);

    // asynchronous reset mid-cycle
    #3 i_rstn = 1'b0;
    #1 check("async_reset", {stat(), o_bitslip}, 18'h0);
    base = pulse_cnt;
    @(posedge i_lvds_clk); #1;
    for (int i = 0; i < 3; i++) drive(1, 48'h0, 0);
    i_rstn = 1'b1;
    for (int i = 0; i < 5; i++) drive(1, 48'h0, 0);
    check("post_reset_idle", stat(), 14'h0);
    check("post_reset_no_pulse", pulse_cnt - base, 0);

    // never matching: 12 slips, wrap twice, fail on 13th mismatch
    base = pulse_cnt;
    drive(0, '0, 1);
    for (int i = 1; i <= 12; i++) exp_q.push_back({3'(i % 6), 8'(i)});
    for (int i = 0; i < 300 && !o_align_fail; i++) drive(1, 48'h0, 0);
    check("s3_fail", stat(), {3'b010, 3'd0, 8'd12});
    check("s3_queue_empty", exp_q.size(), 0);
    for (int i = 0; i < 20; i++) drive(1, 48'h0, 0);
    check("s3_pulses", pulse_cnt - base, 12);
    check("s3_still_fail", stat(), {3'b010, 3'd0, 8'd12});

    // restart from FAIL, then again mid-SETTLE on a coincident training word
    drive(0, '0, 1);
    check("s4_restart_fail", stat(), {3'b001, 3'd0, 8'd0});
    exp_q.push_back({3'd1, 8'd1});
    drive(1, 48'h0, 0);
    drive(1, 48'h0, 0);
    drive(1, 48'h0, 0);
    drive(1, 48'h0, 0);
    check("s4_in_settle", stat(), {3'b001, 3'd1, 8'd1});
    drive(1, TRAIN, 1);
    check("s4_restart_settle", stat(), {3'b001, 3'd1, 8'd0});
    for (int i = 0; i < 15; i++) drive(1, TRAIN, 0);
    check("s4_before_16th", stat(), {3'b001, 3'd1, 8'd0});
    drive(1, TRAIN, 0);
    check("s4_locked", stat(), {3'b100, 3'd1, 8'd0});
    check("s4_queue_empty", exp_q.size(), 0);

    // partial match: 10 good, 1 bad, then a full run of 16
    base = pulse_cnt;
    drive(0, '0, 1);
    for (int i = 0; i < 10; i++) drive(1, TRAIN, 0);
    exp_q.push_back({3'd2, 8'd1});
    drive(1, 48'h123456789ABC, 0);
    for (int i = 0; i < 5; i++) drive(1, TRAIN, 0);
    for (int i = 0; i < 15; i++) drive(1, TRAIN, 0);
    check("s5_before_16th", stat(), {3'b001, 3'd2, 8'd1});
    drive(1, TRAIN, 0);
    check("s5_locked", stat(), {3'b100, 3'd2, 8'd1});
    check("s5_pulses", pulse_cnt - base, 1);

    // watchdog (or its absence) with no valid strobes
    drive(0, '0, 1);
`ifdef ALIGN_TIMEOUT_EN
    for (int i = 0; i < 63; i++) drive(0, '0, 0);
    check("wd_before_64", stat(), {3'b001, 3'd2, 8'd0});
    drive(0, '0, 0);
    check("wd_fail_at_64", stat(), {3'b010, 3'd2, 8'd0});
`else
    for (int i = 0; i < 300; i++) drive(0, '0, 0);
    check("no_wd_waits", stat(), {3'b001, 3'd2, 8'd0});
`endif
    check("final_queue_empty", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
